// File: rtl/nanorisc_fetch_unit.sv
// ============================================================================
// Module   : nanorisc_fetch_unit
// Purpose  : NanoRisc instruction fetch stage. Owns the PC, fetches over a
//            req/ack handshake and presents one instruction per EXEC cycle.
//            Optional single-step mode: define FETCH_SINGLE_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nanorisc_fetch_unit #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 8,
    parameter int OFF_W    = 5,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [2:0]         opcode,
    output logic [INSTR_W-4:0] instr_field,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    input  logic               pc_write,
    input  logic               is_branch,
    input  logic               alu_zero,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic               step_req,
`endif
    output logic               halted
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_WAIT      = 3'd1,
        ST_EXEC      = 3'd2,
        ST_HALTED    = 3'd3
`ifdef FETCH_SINGLE_STEP_EN
        ,
        ST_STEP_HOLD = 3'd4
`endif
    } state_t;

    // State entered out of reset and after every non-halting EXEC.
`ifdef FETCH_SINGLE_STEP_EN
    localparam state_t C_IDLE_STATE = ST_STEP_HOLD;
`else
    localparam state_t C_IDLE_STATE = ST_FETCH;
`endif

    localparam logic [PC_W-1:0] C_RESET_PC = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] C_PC_ONE   = PC_W'(1);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [PC_W-1:0]     w_off_ext;

    assign w_off_ext = PC_W'($signed(ir_q[OFF_W-1:0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_IDLE_STATE;
            pc_q    <= C_RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!pc_write) begin
                    state_d = ST_HALTED;
                end else begin
                    // bne: branch only when the ULA result was non-zero
                    if (is_branch && !alu_zero) begin
                        pc_d = pc_q + w_off_ext;
                    end else begin
                        pc_d = pc_q + C_PC_ONE;
                    end
                    state_d = C_IDLE_STATE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
`ifdef FETCH_SINGLE_STEP_EN
            ST_STEP_HOLD: begin
                if (step_req) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = C_IDLE_STATE;
            end
        endcase
    end

    assign imem_req    = (state_q == ST_WAIT);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALTED);
    assign pc          = pc_q;
    assign opcode      = ir_q[INSTR_W-1 -: 3];
    assign instr_field = ir_q[INSTR_W-4:0];

endmodule

`default_nettype wire

// File: tb/tb_nanorisc_fetch_unit.sv
// ============================================================================
// Module   : tb_nanorisc_fetch_unit
// Purpose  : Directed self-checking bench for nanorisc_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nanorisc_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [2:0] opcode;
    logic [4:0] instr_field;
    logic       instr_valid;
    logic [7:0] pc;
    logic       pc_write;
    logic       is_branch;
    logic       alu_zero;
    logic       halted;
`ifdef FETCH_SINGLE_STEP_EN
    logic       step_req;
`endif

    int total = 0;
    int bad   = 0;

    nanorisc_fetch_unit #(
        .PC_W    (8),
        .INSTR_W (8),
        .OFF_W   (5),
        .RESET_PC(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .opcode     (opcode),
        .instr_field(instr_field),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_write   (pc_write),
        .is_branch  (is_branch),
        .alu_zero   (alu_zero),
`ifdef FETCH_SINGLE_STEP_EN
        .step_req   (step_req),
`endif
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Memory/control-unit driver for one instruction, starting in FETCH.
    // Acks after `delay` extra request cycles; drives garbage data until then.
    task automatic run_instr(input logic [7:0] data, input int delay,
                             input logic pw, input logic br, input logic z,
                             output logic [7:0] addr, output int req_cyc,
                             output int cyc, output logic seen_valid,
                             output logic [2:0] opc, output logic [4:0] fld,
                             output logic addr_stable);
        addr        = 8'hxx;
        req_cyc     = 0;
        cyc         = 0;
        seen_valid  = 1'b0;
        opc         = 3'bxxx;
        fld         = 5'bxxxxx;
        addr_stable = 1'b1;
        pc_write    = pw;
        is_branch   = br;
        alu_zero    = z;
        while (!instr_valid && cyc < 30) begin
            imem_ack  = 1'b0;
            imem_data = ~data;
            if (imem_req) begin
                if (req_cyc == 0) addr = imem_addr;
                else if (imem_addr !== addr) addr_stable = 1'b0;
                req_cyc++;
                if (req_cyc > delay) begin
                    imem_ack  = 1'b1;
                    imem_data = data;
                end else if (opcode !== 3'b000 && req_cyc == 2) begin
                    addr_stable = addr_stable;
                end
            end
            tick();
            cyc++;
        end
        imem_ack = 1'b0;
        if (instr_valid) begin
            seen_valid = 1'b1;
            opc        = opcode;
            fld        = instr_field;
        end
        tick();
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 8'd0)          begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
        total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (halted !== 1'b0)      begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (opcode !== 3'd0)      begin bad++; $display("FAIL reset_opcode: got %0d want 0", opcode); end
        total++; if (instr_field !== 5'd0) begin bad++; $display("FAIL reset_field: got %0d want 0", instr_field); end
    endtask

    task automatic test_sequential();
        logic [7:0] a; int rc; int c; logic v; logic [2:0] o; logic [4:0] f; logic st;
        for (int i = 0; i < 4; i++) begin
            run_instr({3'b000, 5'(i + 1)}, 0, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
            total++; if (a !== 8'(i))      begin bad++; $display("FAIL seq_addr[%0d]: got %0d want %0d", i, a, i); end
            total++; if (c !== 3)          begin bad++; $display("FAIL seq_cycles[%0d]: got %0d want 3", i, c); end
            total++; if (v !== 1'b1)       begin bad++; $display("FAIL seq_valid[%0d]: got %b want 1", i, v); end
            total++; if (o !== 3'b000)     begin bad++; $display("FAIL seq_opcode[%0d]: got %0d want 0", i, o); end
            total++; if (f !== 5'(i + 1))  begin bad++; $display("FAIL seq_field[%0d]: got %0d want %0d", i, f, i + 1); end
        end
        total++; if (pc !== 8'd4) begin bad++; $display("FAIL seq_pc_end: got %0d want 4", pc); end
    endtask

    task automatic test_wait_states();
        logic [7:0] a; int rc; int c; logic v; logic [2:0] o; logic [4:0] f; logic st;
        run_instr(8'h00, 0, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        run_instr(8'b101_01010, 4, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        total++; if (a !== 8'd5)      begin bad++; $display("FAIL wait_addr: got %0d want 5", a); end
        total++; if (st !== 1'b1)     begin bad++; $display("FAIL wait_addr_stable: got %b want 1", st); end
        total++; if (rc !== 5)        begin bad++; $display("FAIL wait_req_cycles: got %0d want 5", rc); end
        total++; if (c !== 7)         begin bad++; $display("FAIL wait_latency: got %0d want 7", c); end
        total++; if (o !== 3'b101)    begin bad++; $display("FAIL wait_opcode: got %0d want 5", o); end
        total++; if (f !== 5'b01010)  begin bad++; $display("FAIL wait_field: got %0d want 10", f); end
        total++; if (pc !== 8'd6)     begin bad++; $display("FAIL wait_pc_end: got %0d want 6", pc); end
    endtask

    task automatic test_branch();
        logic [7:0] a; int rc; int c; logic v; logic [2:0] o; logic [4:0] f; logic st;
        for (int i = 6; i < 10; i++) run_instr(8'h00, 0, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        run_instr(8'b111_11101, 0, 1'b1, 1'b1, 1'b0, a, rc, c, v, o, f, st);
        total++; if (a !== 8'd10) begin bad++; $display("FAIL bne_taken_addr: got %0d want 10", a); end
        total++; if (pc !== 8'd7) begin bad++; $display("FAIL bne_taken_pc: got %0d want 7", pc); end
        for (int i = 7; i < 10; i++) run_instr(8'h00, 0, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        run_instr(8'b111_11101, 0, 1'b1, 1'b1, 1'b1, a, rc, c, v, o, f, st);
        total++; if (pc !== 8'd11) begin bad++; $display("FAIL bne_not_taken_pc: got %0d want 11", pc); end
        run_instr(8'b111_00101, 0, 1'b1, 1'b1, 1'b0, a, rc, c, v, o, f, st);
        total++; if (pc !== 8'd16) begin bad++; $display("FAIL bne_fwd_pc: got %0d want 16", pc); end
        run_instr(8'b111_00000, 0, 1'b1, 1'b1, 1'b0, a, rc, c, v, o, f, st);
        total++; if (pc !== 8'd16) begin bad++; $display("FAIL bne_zero_off_pc: got %0d want 16", pc); end
        run_instr(8'b111_00000, 0, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        total++; if (a !== 8'd16)  begin bad++; $display("FAIL bne_zero_off_refetch: got %0d want 16", a); end
        total++; if (pc !== 8'd17) begin bad++; $display("FAIL nonbranch_off_pc: got %0d want 17", pc); end
    endtask

    task automatic test_halt();
        logic [7:0] a; int rc; int c; logic v; logic [2:0] o; logic [4:0] f; logic st;
        int req_seen; int valid_seen;
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(8'h00, 0, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        run_instr(8'b011_00110, 0, 1'b0, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b want 1", halted); end
        req_seen = 0; valid_seen = 0;
        imem_ack = 1'b1; imem_data = 8'hFF; pc_write = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_req)    req_seen++;
            if (instr_valid) valid_seen++;
            tick();
        end
        imem_ack = 1'b0;
        total++; if (req_seen !== 0)   begin bad++; $display("FAIL halt_req: got %0d cycles want 0", req_seen); end
        total++; if (valid_seen !== 0) begin bad++; $display("FAIL halt_valid: got %0d cycles want 0", valid_seen); end
        total++; if (pc !== 8'd4)      begin bad++; $display("FAIL halt_pc: got %0d want 4", pc); end
        total++; if (opcode !== 3'b011 || instr_field !== 5'b00110)
            begin bad++; $display("FAIL halt_ir_frozen: got %0d/%0d want 3/6", opcode, instr_field); end
        total++; if (halted !== 1'b1)  begin bad++; $display("FAIL halt_sticky: got %b want 1", halted); end
        do_reset();
        total++; if (pc !== 8'd0)      begin bad++; $display("FAIL halt_reset_pc: got %0d want 0", pc); end
        total++; if (halted !== 1'b0)  begin bad++; $display("FAIL halt_reset_flag: got %b want 0", halted); end
    endtask

    task automatic test_wrap_and_reset();
        logic [7:0] a; int rc; int c; logic v; logic [2:0] o; logic [4:0] f; logic st;
        run_instr(8'b000_11111, 0, 1'b1, 1'b1, 1'b0, a, rc, c, v, o, f, st);
        total++; if (pc !== 8'd255) begin bad++; $display("FAIL wrap_neg_pc: got %0d want 255", pc); end
        run_instr(8'h00, 0, 1'b1, 1'b0, 1'b0, a, rc, c, v, o, f, st);
        total++; if (a !== 8'd255)  begin bad++; $display("FAIL wrap_addr: got %0d want 255", a); end
        total++; if (pc !== 8'd0)   begin bad++; $display("FAIL wrap_pc: got %0d want 0", pc); end
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL midfetch_req_before: got %b want 1", imem_req); end
        reset = 1'b1;
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midfetch_req_dropped: got %b want 0", imem_req); end
        reset = 1'b0; imem_ack = 1'b1; imem_data = 8'hFF;
        tick();
        imem_ack = 1'b0;
        total++; if (opcode !== 3'd0 || instr_field !== 5'd0)
            begin bad++; $display("FAIL late_ack_ir: got %0d/%0d want 0/0", opcode, instr_field); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL late_ack_valid: got %b want 0", instr_valid); end
        total++; if (pc !== 8'd0)       begin bad++; $display("FAIL late_ack_pc: got %0d want 0", pc); end
    endtask

`ifdef FETCH_SINGLE_STEP_EN
    task automatic test_single_step();
        int req_seen; int valid_seen;
        step_req = 1'b0; pc_write = 1'b1; is_branch = 1'b0; alu_zero = 1'b0;
        do_reset();
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) req_seen++;
            tick();
        end
        total++; if (req_seen !== 0) begin bad++; $display("FAIL step_idle_req: got %0d want 0", req_seen); end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            imem_ack = imem_req; imem_data = 8'h00;
            if (instr_valid) valid_seen++;
            tick();
        end
        imem_ack = 1'b0;
        total++; if (valid_seen !== 1) begin bad++; $display("FAIL step_one_instr: got %0d want 1", valid_seen); end
        total++; if (pc !== 8'd1)      begin bad++; $display("FAIL step_pc: got %0d want 1", pc); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL step_hold_req: got %b want 0", imem_req); end
    endtask
`endif

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_data = 8'h00;
        pc_write = 1'b0; is_branch = 1'b0; alu_zero = 1'b0;
`ifdef FETCH_SINGLE_STEP_EN
        step_req = 1'b0;
        test_single_step();
`else
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_halt();
        test_wrap_and_reset();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nanorisc_fetch_unit.md
Name: nanorisc_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the NanoRisc control unit. It owns the program counter and fetches each instruction from instruction memory over a req/ack handshake. It latches the instruction into an instruction register and presents the 3-bit opcode and operand field to the control unit for one execute cycle. It then advances the PC sequentially, takes a bne branch, or halts, as directed by the control unit's PCWrite and isBranch outputs and the ULA zero flag.

Parameters:
PC_W, 8, program-counter and instruction-address width; PC arithmetic wraps modulo 2^PC_W
INSTR_W, 8, instruction width; opcode = instr[INSTR_W-1 -: 3]
OFF_W, 5, branch offset width; offset = instr[OFF_W-1:0], two's complement, must satisfy OFF_W <= INSTR_W-3
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_W  fetch address (equals PC)
imem_ack  input  1  memory has valid data this cycle
imem_data  input  INSTR_W  instruction word, valid when imem_ack=1
opcode  output  3  opcode of latched instruction, to control unit
instr_field  output  INSTR_W-3  non-opcode bits of latched instruction
instr_valid  output  1  high exactly during the EXEC cycle
pc  output  PC_W  current PC
pc_write  input  1  control-unit PCWrite, sampled in EXEC
is_branch  input  1  control-unit isBranch, sampled in EXEC
alu_zero  input  1  ULA result == 0, sampled in EXEC
halted  output  1  core halted

Behaviour:
- Synchronous, active-high reset, single clock domain (clk); reset has priority over every other event.
- Reset values: PC=RESET_PC, IR=0, state=FETCH, imem_req=0, instr_valid=0, halted=0, opcode=0, instr_field=0.
- States: FETCH, WAIT, EXEC, HALTED.
- FETCH: imem_req=0; move to WAIT next cycle. This gives one idle bubble after reset and between instructions.
- WAIT:
  - imem_req=1 and imem_addr=PC, both held stable until ack.
  - On imem_ack=1, load IR<=imem_data and go to EXEC. imem_req drops the cycle after ack.
  - No timeout; a missing ack stalls indefinitely.
- imem_ack in any state other than WAIT is ignored; IR is unchanged.
- EXEC (exactly one cycle): instr_valid=1; opcode and instr_field driven from IR. pc_write, is_branch and alu_zero are sampled at the end of this cycle:
  - pc_write=0: PC unchanged; go to HALTED.
  - pc_write=1, is_branch=1, alu_zero=0 (bne taken): PC <= PC + sign_extend(IR[OFF_W-1:0]) to PC_W bits; go to FETCH.
  - otherwise: PC <= PC + 1; go to FETCH.
- HALTED: halted=1, imem_req=0, instr_valid=0. PC and IR frozen; only reset exits.
- opcode and instr_field hold the last IR value in every state; they are qualified only by instr_valid.
- Wrap-around: PC = 2^PC_W-1 plus 1 gives 0. Negative offsets below 0 wrap modulo 2^PC_W.
- Offset 0 on a taken branch re-fetches the same address (tight loop); this is legal.
- Reset asserted in WAIT drops imem_req on the next edge. A late ack after reset is ignored because the FSM is in FETCH.
- Latency: 3 cycles per instruction (FETCH, WAIT with same-cycle ack, EXEC); each extra memory wait cycle adds 1.

Optional Feature:
FETCH_SINGLE_STEP_EN
- Defined:
  - Adds input step_req (1 bit) and state STEP_HOLD.
  - After each EXEC that does not halt, the FSM enters STEP_HOLD instead of FETCH. It waits there with imem_req=0 until step_req=1 is sampled, then goes to FETCH.
  - Immediately after reset, the FSM also enters STEP_HOLD instead of FETCH.
  - step_req is ignored in all other states.
- Not defined: no step_req port; behaviour exactly as above.

Test Plan:
- Reset, then sequential fetch: memory acks same cycle with opcode 000 words; pc_write=1, is_branch=0 -> imem_addr 0,1,2,3, instr_valid pulses every 3rd cycle, opcode=000.
- Memory wait states: ack delayed 4 cycles at PC=5 -> imem_req held high with imem_addr=5 for 5 cycles; IR loaded only on ack; instr_valid 1 cycle later.
- bne taken/not taken at PC=10, offset=5'b11101 (-3): alu_zero=0 -> next imem_addr=7; alu_zero=1 -> next imem_addr=11.
- Halt: EXEC with pc_write=0 at PC=4 -> halted=1, imem_req stays 0 for 20 cycles, pc=4; reset -> pc=RESET_PC, halted=0.
- Wrap and reset mid-fetch: PC=255 sequential -> next imem_addr=0; assert reset during WAIT with ack arriving the following cycle -> imem_req=0, IR stays 0.
- With FETCH_SINGLE_STEP_EN: after reset no imem_req until step_req pulse; one pulse -> exactly one instr_valid pulse, then FSM idles in STEP_HOLD.
